iq_frame_packer: RTL and testbench
==================================

Name: iq_frame_packer

Overview:
- Parametrised serialiser between the N-channel receiver bank and the 16-bit IQ-to-USB FIFO, all on the ADC clock.
- On each decimated-sample strobe it captures the I/Q bus of all receivers. It then emits one framed burst of 16-bit words containing only the channels enabled by a multibus-supplied mask.
- Each burst starts with a sync word and a sequence/channel-count word.
- Back-pressure comes from the FIFO full flag. Samples dropped while a frame is still draining are counted.

Parameters:
- NUM_CH, 7: receiver channel count, 1..16.
- SAMPLE_W, 32: width of each I and each Q sample. Must be a multiple of 16.
- SYNC_WORD, 16'hA5A5: first word of every frame.
- OVR_W, 16: overrun counter width.

Ports:
- clock  in  1  ADC clock; all logic is on rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  one-cycle strobe meaning new samples are present (driven by fir_done).
- in_data  in  NUM_CH*2*SAMPLE_W  channel k occupies [k*2W+W-1:k*2W] for I and [k*2W+2W-1:k*2W+W] for Q.
- ch_mask  in  NUM_CH  channel enables; bit k enables channel k.
- out_data  out  16  output word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the word; driven as ~wrfull.
- frame_busy  out  1  high from capture until the last word of the frame is accepted.
- ovr_count  out  OVR_W  count of dropped strobes; saturating.
- ovr_clear  in  1  synchronous clear of ovr_count.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, out_valid=0, out_data=0, frame_busy=0, seq=0, ovr_count=0.
  - Reset mid-frame abandons the frame immediately; the partial frame is not completed.
- States:
  - IDLE: in_valid with (ch_mask & all-ones)!=0 → capture in_data and ch_mask into shadow registers, go to SYNC.
    - in_valid with mask==0 → stay in IDLE; nothing is emitted, seq is unchanged, and it is not counted as overrun.
  - SYNC: out_data=SYNC_WORD.
  - INFO: out_data={seq[7:0], popcount(mask)[7:0]}.
  - DATA: walk the enabled channels in ascending index order. Per channel emit I then Q, each as SAMPLE_W/16 words, MS word first.
- Word transfer:
  - A word transfers on any edge where out_valid && out_ready.
  - The state/word index advances only on a transfer. out_data and out_valid are registered and held stable while out_ready=0.
- Latency: in_valid at edge n → out_valid=1 with SYNC_WORD visible after edge n+1. No bubbles between words while out_ready=1.
- Frame length: 2 + popcount(mask)*2*(SAMPLE_W/16) words. With defaults and all 7 channels enabled that is 30 words.
- End of frame: on transfer of the last word, out_valid deasserts, frame_busy drops, seq increments (8-bit, wraps 255→0), and state returns to IDLE. IDLE at the next edge can capture again.
- Overrun: in_valid while state!=IDLE (including the cycle the last word transfers) drops that sample and increments ovr_count.
  - ovr_count saturates at all-ones.
  - If ovr_clear and an overrun occur in the same cycle, ovr_clear wins and the result is 0.
- Mask changes during a frame do not affect that frame; the shadow mask is used.
- in_data is sampled only on the capture edge; later changes are ignored.

Decomposition:
- Shared package iq_frame_pkg holds:
  - the state enum {IDLE, SYNC, INFO, DATA};
  - SYNC_WORD default;
  - a words_per_sample(SAMPLE_W) constant function;
  - a popcount function.
- One sub-module, ch_index_finder: combinational next-enabled-channel search (priority encoder over mask bits above current index). It is used to skip disabled channels in a single cycle.

Test Plan:
- Defaults, mask=7'h7F, out_ready=1, ch k I=32'h1000_0000+k, Q=32'h2000_0000+k → 30 contiguous words starting A5A5, 0007, 1000, 0000, 2000, 0000, 1000, 0001…; first valid one cycle after in_valid.
- mask=7'b0100101, seq previously 3 → 14 words: A5A5, 0303, then ch0, ch2, ch5 I/Q words only; seq becomes 4.
- out_ready held low 5 cycles after 4th word, mask=7'h7F, defaults → out_data frozen on word 4 for all 5 cycles; total frame remains 30 words, none duplicated or lost.
- Second in_valid 10 cycles into a frame, then ovr_clear with simultaneous in_valid overrun → ovr_count=1 after the first, then 0; the frame in progress completes unchanged.
- mask=0 with in_valid → no out_valid, seq and ovr_count unchanged; 256 frames → INFO upper byte wraps from 0xFF to 0x00.
- reset_n low during word 12 → next cycle out_valid=0, frame_busy=0, seq=0; the next in_valid produces a full frame starting with SYNC_WORD.

Source files
------------

// File: rtl/iq_frame_pkg.sv
// Shared types and helpers for the IQ frame packer.
//   state_t           : frame FSM states
//   SYNC_WORD_DEFAULT : default first word of every frame
//   words_per_sample  : 16-bit words needed for one I or Q sample
//   popcount          : number of set bits in a (zero-extended) channel mask
package iq_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        INFO = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5A5;
    localparam int          MAX_CH            = 16;

    function automatic int words_per_sample(input int sample_w);
        return sample_w / 16;
    endfunction

    function automatic logic [7:0] popcount(input logic [MAX_CH-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ch_index_finder.sv
// Next-enabled-channel search.
//   mask      : channel enables
//   start_idx : lowest index that may be returned (may equal NUM_CH)
//   found     : some enabled channel exists at or above start_idx
//   next_idx  : lowest such channel index
module ch_index_finder #(
    parameter int NUM_CH = 7,
    parameter int IDX_W  = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W-1:0]  start_idx,
    output logic              found,
    output logic [IDX_W-1:0]  next_idx
);

    // Descending scan so the lowest qualifying index is written last.
    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (IDX_W'(i) >= start_idx)) begin
                found    = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/iq_frame_packer.sv
// Serialises one captured set of receiver I/Q samples into a framed burst of
// 16-bit words: SYNC_WORD, {seq, channel count}, then I and Q of every
// enabled channel (ascending index, MS word first).
//   clock, reset_n      : ADC clock, synchronous active-low reset
//   in_valid, in_data   : sample strobe and packed I/Q bus of all channels
//   ch_mask             : channel enables, latched at capture
//   out_data/out_valid/out_ready : registered word stream with back-pressure
//   frame_busy          : frame in progress
//   ovr_count/ovr_clear : saturating count of strobes dropped mid-frame
//
// state | meaning
// IDLE  | waiting for a strobe with a non-empty mask
// SYNC  | presenting SYNC_WORD
// INFO  | presenting {seq, popcount(mask)}
// DATA  | presenting sample words of the current channel
module iq_frame_packer
    import iq_frame_pkg::*;
#(
    parameter int          NUM_CH    = 7,
    parameter int          SAMPLE_W  = 32,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int          OVR_W     = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic [NUM_CH*2*SAMPLE_W-1:0] in_data,
    input  logic [NUM_CH-1:0]            ch_mask,
    output logic [15:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         frame_busy,
    output logic [OVR_W-1:0]             ovr_count,
    input  logic                         ovr_clear
);

    localparam int WPS    = words_per_sample(SAMPLE_W);
    localparam int WPC    = 2 * WPS;
    localparam int WORD_W = $clog2(WPC);
    localparam int IDX_W  = $clog2(NUM_CH + 1);
    localparam int DATA_W = NUM_CH * 2 * SAMPLE_W;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]    ch_q, ch_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [7:0]          seq_q, seq_d;
    logic [15:0]         out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [OVR_W-1:0]    ovr_q, ovr_d;

    logic                xfer;
    logic [NUM_CH-1:0]   find_mask;
    logic [IDX_W-1:0]    find_start;
    logic                find_found;
    logic [IDX_W-1:0]    find_idx;

    // Words of every captured channel in emission order: I words then Q words.
    logic [15:0] words [NUM_CH][WPC];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar k = 0; k < WPC; k++) begin : g_word
            localparam int LSB = c * 2 * SAMPLE_W +
                ((k < WPS) ? (SAMPLE_W - 16 * (k + 1))
                           : (2 * SAMPLE_W - 16 * (k - WPS + 1)));
            assign words[c][k] = data_q[LSB +: 16];
        end
    end

    function automatic logic [15:0] pick_word(input logic [IDX_W-1:0]  ch,
                                              input logic [WORD_W-1:0] w);
        logic [15:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < WPC; k++) begin
                if ((IDX_W'(c) == ch) && (WORD_W'(k) == w)) begin
                    r = words[c][k];
                end
            end
        end
        return r;
    endfunction

    // In IDLE the finder locates the first channel of the incoming mask;
    // otherwise it looks for the next enabled channel after the current one.
    assign find_mask  = (state_q == IDLE) ? ch_mask : mask_q;
    assign find_start = (state_q == IDLE) ? '0 : ch_q + IDX_W'(1);

    ch_index_finder #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_finder (
        .mask      (find_mask),
        .start_idx (find_start),
        .found     (find_found),
        .next_idx  (find_idx)
    );

    assign xfer = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        word_d      = word_q;
        seq_d       = seq_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovr_d       = ovr_q;

        case (state_q)
            IDLE: begin
                if (in_valid && (|ch_mask)) begin
                    data_d      = in_data;
                    mask_d      = ch_mask;
                    ch_d        = find_idx;
                    word_d      = '0;
                    out_data_d  = SYNC_WORD;
                    out_valid_d = 1'b1;
                    state_d     = SYNC;
                end
            end
            SYNC: begin
                if (xfer) begin
                    out_data_d = {seq_q, popcount(MAX_CH'(mask_q))};
                    state_d    = INFO;
                end
            end
            INFO: begin
                if (xfer) begin
                    word_d     = '0;
                    out_data_d = pick_word(ch_q, '0);
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (word_q == WORD_W'(WPC - 1)) begin
                        if (find_found) begin
                            ch_d       = find_idx;
                            word_d     = '0;
                            out_data_d = pick_word(find_idx, '0);
                        end else begin
                            out_valid_d = 1'b0;
                            seq_d       = seq_q + 8'd1;
                            state_d     = IDLE;
                        end
                    end else begin
                        word_d     = word_q + WORD_W'(1);
                        out_data_d = pick_word(ch_q, word_q + WORD_W'(1));
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        if (in_valid && (state_q != IDLE) && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
        if (ovr_clear) begin
            ovr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            ch_q        <= '0;
            word_q      <= '0;
            seq_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            word_q      <= word_d;
            seq_q       <= seq_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_busy = (state_q != IDLE);
    assign ovr_count  = ovr_q;

endmodule

// File: tb/tb_iq_frame_packer.sv
module tb_iq_frame_packer;

    localparam int NUM_CH   = 7;
    localparam int SAMPLE_W = 32;
    localparam int DATA_W   = NUM_CH * 2 * SAMPLE_W;

    logic              clock;
    logic              reset_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [NUM_CH-1:0] ch_mask;
    logic [15:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              frame_busy;
    logic [15:0]       ovr_count;
    logic              ovr_clear;

    int          errors;
    int          checks;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    logic [7:0]  seq_m;

    iq_frame_packer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .ch_mask    (ch_mask),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_busy (frame_busy),
        .ovr_count  (ovr_count),
        .ovr_clear  (ovr_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pattern();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            d = d | (DATA_W'({32'h2000_0000 + 32'(k), 32'h1000_0000 + 32'(k)}) << (64 * k));
        end
        return d;
    endfunction

    task automatic build_exp(input logic [NUM_CH-1:0] m, input logic [7:0] s);
        logic [7:0]  pc;
        logic [31:0] iv;
        logic [31:0] qv;
        exp_q.delete();
        pc = '0;
        for (int k = 0; k < NUM_CH; k++) if (m[k]) pc = pc + 8'd1;
        exp_q.push_back(16'hA5A5);
        exp_q.push_back({s, pc});
        for (int k = 0; k < NUM_CH; k++) begin
            if (m[k]) begin
                iv = 32'h1000_0000 + 32'(k);
                qv = 32'h2000_0000 + 32'(k);
                exp_q.push_back(iv[31:16]);
                exp_q.push_back(iv[15:0]);
                exp_q.push_back(qv[31:16]);
                exp_q.push_back(qv[15:0]);
            end
        end
    endtask

    task automatic start_frame(input logic [NUM_CH-1:0] m);
        ch_mask  = m;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Drains the frame currently on the bus. Optional stall after stall_at
    // transferred words, stray strobe at inj_at, strobe+clear at clr_at.
    task automatic run_frame(input int stall_at, input int stall_len,
                             input int inj_at, input int clr_at);
        int cyc;
        bit stalled;
        got.delete();
        cyc     = 0;
        stalled = 0;
        while (out_valid === 1'b1 && cyc < 200) begin
            if (got.size() == stall_at && !stalled) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    check16("stall_hold_data", out_data, exp_q[stall_at]);
                    check1("stall_hold_valid", out_valid, 1'b1);
                end
                out_ready = 1'b1;
                stalled   = 1;
            end
            if (got.size() == inj_at) in_valid = 1'b1;
            if (got.size() == clr_at) begin
                in_valid  = 1'b1;
                ovr_clear = 1'b1;
            end
            got.push_back(out_data);
            step();
            in_valid  = 1'b0;
            ovr_clear = 1'b0;
            if (got.size() == inj_at + 1) check16("ovr_after_drop", ovr_count, 16'd1);
            if (got.size() == clr_at + 1) check16("ovr_after_clear", ovr_count, 16'd0);
            cyc++;
        end
        check1("frame_end_valid", out_valid, 1'b0);
        check1("frame_end_busy", frame_busy, 1'b0);
    endtask

    task automatic compare_frame(input string tag);
        check16({tag, "_len"}, 16'(got.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check16($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = pattern();
        ch_mask   = '0;
        out_ready = 1'b1;
        ovr_clear = 1'b0;
        seq_m     = 8'd0;

        // Reset state
        step();
        step();
        check1("rst_valid", out_valid, 1'b0);
        check16("rst_data", out_data, 16'h0000);
        check1("rst_busy", frame_busy, 1'b0);
        check16("rst_ovr", ovr_count, 16'h0000);
        reset_n = 1'b1;
        step();

        // Full mask, contiguous 30-word frame, one-cycle latency
        build_exp(7'h7F, seq_m);
        start_frame(7'h7F);
        check1("lat_valid", out_valid, 1'b1);
        check16("lat_sync", out_data, 16'hA5A5);
        check1("lat_busy", frame_busy, 1'b1);
        run_frame(-1, 0, -1, -1);
        compare_frame("full");
        seq_m = seq_m + 8'd1;

        // Back-pressure: 5 stalled cycles after 4 words
        build_exp(7'h7F, seq_m);
        start_frame(7'h7F);
        run_frame(4, 5, -1, -1);
        compare_frame("stall");
        seq_m = seq_m + 8'd1;

        // Overrun, overrun+clear, and shadowing of data/mask
        build_exp(7'h7F, seq_m);
        start_frame(7'h7F);
        in_data = '1;
        ch_mask = 7'h01;
        run_frame(-1, 0, 10, 20);
        compare_frame("ovr");
        seq_m   = seq_m + 8'd1;
        in_data = pattern();

        // Sparse mask with seq 3
        build_exp(7'b0100101, seq_m);
        start_frame(7'b0100101);
        run_frame(-1, 0, -1, -1);
        compare_frame("sparse");
        check16("sparse_info", got[1], 16'h0303);
        seq_m = seq_m + 8'd1;

        // Empty mask: ignored completely
        start_frame(7'h00);
        check1("mask0_valid", out_valid, 1'b0);
        check1("mask0_busy", frame_busy, 1'b0);
        step();
        check1("mask0_valid2", out_valid, 1'b0);
        check16("mask0_ovr", ovr_count, 16'h0000);

        // Sequence counter wrap 255 -> 0
        for (int f = 0; f < 253; f++) begin
            start_frame(7'h01);
            run_frame(-1, 0, -1, -1);
            check16($sformatf("wrap_info_%0d", f), got[1], {seq_m, 8'd1});
            seq_m = seq_m + 8'd1;
        end
        check16("wrap_seq_now", {8'd0, seq_m}, 16'h0001);

        // Reset mid-frame while word 12 is on the bus
        build_exp(7'h7F, seq_m);
        start_frame(7'h7F);
        for (int i = 0; i < 11; i++) step();
        check16("pre_rst_word12", out_data, exp_q[11]);
        reset_n = 1'b0;
        step();
        check1("midrst_valid", out_valid, 1'b0);
        check1("midrst_busy", frame_busy, 1'b0);
        check16("midrst_data", out_data, 16'h0000);
        reset_n = 1'b1;
        seq_m   = 8'd0;
        build_exp(7'h7F, seq_m);
        start_frame(7'h7F);
        check16("postrst_sync", out_data, 16'hA5A5);
        run_frame(-1, 0, -1, -1);
        compare_frame("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
